// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO bus arbiter: FSM states, write-enable
// encoding and the GPIO register map.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // we[2] is the write strobe; we[1:0] is the access size
  localparam int unsigned WE_WR_BIT = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [11:0] REG_DFILTER = 12'h000;
  localparam logic [11:0] REG_REFCLK  = 12'h004;
  localparam logic [11:0] REG_IN      = 12'h010;
  localparam logic [11:0] REG_OUT     = 12'h020;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Signal bundle between the two requesting masters, the arbiter and the GPIO
// register port. The arbiter takes the slave view; masters and peripheral take master.
interface gpio_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [2:0]        m0_we;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [2:0]        m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [2:0]        p_we;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m1_rdata, m1_ack,
    output p_sel, p_addr, p_we, p_wdata,
    input  p_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m1_rdata, m1_ack,
    input  p_sel, p_addr, p_we, p_wdata,
    output p_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way picker: round-robin on ties, or m0-first when fixed is set.
// The pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       fixed,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;  // 1 = m1 wins the next tie

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (fixed || !ptr_q) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) ptr_d = grant[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Shares the GPIO register port between two masters; each grant becomes one
// registered single-cycle peripheral access followed by a one-cycle ack.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  gpio_bus_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [1:0]        req, grant;
  logic              arb_en;
  logic              win_q, win_d;  // owner of the transfer in flight, 1 = m1
  logic              p_sel_q, p_sel_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [2:0]        p_we_q, p_we_d;
  logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] cap_data;

  assign req    = {bus.m1_req, bus.m0_req};
  assign arb_en = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .fixed (FIXED_PRIO),
    .grant (grant)
  );

  // Writes return zero so a stale read value never leaks into a write ack
  assign cap_data = p_we_q[WE_WR_BIT] ? '0 : bus.p_rdata;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    p_sel_d    = p_sel_q;
    p_addr_d   = p_addr_q;
    p_we_d     = p_we_q;
    p_wdata_d  = p_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          win_d     = grant[1];
          p_sel_d   = 1'b1;
          p_addr_d  = grant[1] ? bus.m1_addr  : bus.m0_addr;
          p_we_d    = grant[1] ? bus.m1_we    : bus.m0_we;
          p_wdata_d = grant[1] ? bus.m1_wdata : bus.m0_wdata;
          state_d   = StAccess;
        end
      end
      StAccess: begin
        p_sel_d   = 1'b0;
        p_addr_d  = '0;
        p_we_d    = '0;
        p_wdata_d = '0;
        if (win_q) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = cap_data;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = cap_data;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_q      <= 1'b0;
      p_sel_q    <= 1'b0;
      p_addr_q   <= '0;
      p_we_q     <= '0;
      p_wdata_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      p_sel_q    <= p_sel_d;
      p_addr_q   <= p_addr_d;
      p_we_q     <= p_we_d;
      p_wdata_q  <= p_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
    end
  end

  assign bus.p_sel    = p_sel_q;
  assign bus.p_addr   = p_addr_q;
  assign bus.p_we     = p_we_q;
  assign bus.p_wdata  = p_wdata_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;

endmodule
